// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the cache/memory arbiter.
// The I-cache and D-cache import the same block geometry from here.
package mem_arb_pkg;

    localparam int DW            = 16;  // data word width
    localparam int AW            = 16;  // byte address width
    localparam int WORDS_PER_BLK = 8;   // words per cache block
    localparam int BLK_OFF_BITS  = 4;   // byte offset bits within a 16-byte block
    localparam int WORD_IDX_W    = 3;   // word index width within a block
    localparam int MEM_LAT       = 4;   // read issue to mem_rvalid, in cycles

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_I_FILL  = 2'd1,
        ST_D_FILL  = 2'd2,
        ST_D_WRITE = 2'd3
    } arb_state_e;

    // Byte address of the first word of the block containing addr.
    function automatic logic [AW-1:0] blk_base(input logic [AW-1:0] addr);
        return {addr[AW-1:BLK_OFF_BITS], {BLK_OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side request/fill signals and the memory port.
// master = arbiter view, slave = caches plus memory view.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic                  i_miss;
    logic [AW-1:0]         i_addr;
    logic                  i_fill_we;
    logic                  i_fill_done;
    logic                  d_miss;
    logic [AW-1:0]         d_addr;
    logic                  d_wr_req;
    logic [DW-1:0]         d_wr_data;
    logic                  d_fill_we;
    logic                  d_fill_done;
    logic                  d_wr_done;
    logic [WORD_IDX_W-1:0] fill_idx;
    logic [DW-1:0]         fill_data;
    logic                  mem_en;
    logic                  mem_wr;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW-1:0]         mem_rdata;
    logic                  mem_rvalid;
    logic                  busy;

    modport master (
        input  i_miss, i_addr, d_miss, d_addr, d_wr_req, d_wr_data, mem_rdata, mem_rvalid,
        output i_fill_we, i_fill_done, d_fill_we, d_fill_done, d_wr_done,
               fill_idx, fill_data, mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    modport slave (
        output i_miss, i_addr, d_miss, d_addr, d_wr_req, d_wr_data, mem_rdata, mem_rvalid,
        input  i_fill_we, i_fill_done, d_fill_we, d_fill_done, d_wr_done,
               fill_idx, fill_data, mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/blk_word_cnt.sv
// Word counter within a cache block: synchronous clear (wins over
// increment), increment, and a terminal flag on the last word index.
module blk_word_cnt
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [WORD_IDX_W-1:0] cnt_o,
    output logic                  term_o
);

    logic [WORD_IDX_W-1:0] cnt_q;
    logic [WORD_IDX_W-1:0] cnt_d;

    // Next count: clear has priority, increment wraps 7 -> 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + WORD_IDX_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == {WORD_IDX_W{1'b1}});

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the I-cache and D-cache miss handlers and the unified
// main memory. Grants one requester at a time (store > D miss > I miss),
// then runs an 8-word block fill or a single write-through store.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    arb_state_e            state_q, state_d;
    logic [AW-1:0]         base_q, base_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic                  issue_all_q, issue_all_d;  // all 8 reads issued for this fill
    logic                  cnt_clr;
    logic                  issue_inc;
    logic                  recv_inc;
    logic [WORD_IDX_W-1:0] issue_cnt;
    logic [WORD_IDX_W-1:0] recv_cnt;
    logic                  issue_term;
    logic                  recv_term;
    logic                  in_fill;

    blk_word_cnt u_issue_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (issue_inc),
        .cnt_o  (issue_cnt),
        .term_o (issue_term)
    );

    blk_word_cnt u_recv_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (recv_inc),
        .cnt_o  (recv_cnt),
        .term_o (recv_term)
    );

    assign in_fill = (state_q == ST_I_FILL) || (state_q == ST_D_FILL);

    // Next-state logic and all bus outputs; every output idles at 0.
    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        wdata_d         = wdata_q;
        issue_all_d     = issue_all_q;
        cnt_clr         = 1'b0;
        issue_inc       = 1'b0;
        recv_inc        = 1'b0;
        bus.i_fill_we   = 1'b0;
        bus.i_fill_done = 1'b0;
        bus.d_fill_we   = 1'b0;
        bus.d_fill_done = 1'b0;
        bus.d_wr_done   = 1'b0;
        bus.fill_idx    = '0;
        bus.fill_data   = '0;
        bus.mem_en      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.busy        = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                cnt_clr     = 1'b1;
                issue_all_d = 1'b0;
                if (bus.d_wr_req) begin
                    base_d  = bus.d_addr;
                    wdata_d = bus.d_wr_data;
                    state_d = ST_D_WRITE;
                end else if (bus.d_miss) begin
                    base_d  = blk_base(bus.d_addr);
                    state_d = ST_D_FILL;
                end else if (bus.i_miss) begin
                    base_d  = blk_base(bus.i_addr);
                    state_d = ST_I_FILL;
                end
            end

            ST_I_FILL, ST_D_FILL: begin
                // Read issue side: one word address per cycle until all 8 are out.
                if (!issue_all_q) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = base_q + {{(AW-WORD_IDX_W-1){1'b0}}, issue_cnt, 1'b0};
                    issue_inc    = 1'b1;
                    if (issue_term) begin
                        issue_all_d = 1'b1;
                    end
                end
                // Return side: forward each word to the granted cache.
                if (bus.mem_rvalid) begin
                    bus.i_fill_we = (state_q == ST_I_FILL);
                    bus.d_fill_we = (state_q == ST_D_FILL);
                    bus.fill_idx  = recv_cnt;
                    bus.fill_data = bus.mem_rdata;
                    recv_inc      = 1'b1;
                    if (recv_term) begin
                        bus.i_fill_done = (state_q == ST_I_FILL);
                        bus.d_fill_done = (state_q == ST_D_FILL);
                        state_d         = ST_IDLE;
                    end
                end
            end

            ST_D_WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = base_q;
                bus.mem_wdata = wdata_q;
                bus.d_wr_done = 1'b1;
                state_d       = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            wdata_q     <= '0;
            issue_all_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            issue_all_q <= issue_all_d;
        end
    end

    // A returned word with no fill in progress is dropped; flag it in simulation.
    a_rvalid_in_fill: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.mem_rvalid && !in_fill))
        else $warning("mem_rvalid outside a fill was ignored");

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model
// returning mem[a] = a ^ 16'hA5A5.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic spur  = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: reads come back exactly MEM_LAT cycles after issue.
    logic [MEM_LAT-1:0]         pv;
    logic [MEM_LAT-1:0][AW-1:0] pa;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pa <= '0;
        end else begin
            pv <= {pv[MEM_LAT-2:0], bus.mem_en & ~bus.mem_wr};
            pa <= {pa[MEM_LAT-2:0], bus.mem_addr};
        end
    end

    assign bus.mem_rvalid = pv[MEM_LAT-1] | spur;
    assign bus.mem_rdata  = pv[MEM_LAT-1] ? (pa[MEM_LAT-1] ^ 16'hA5A5) : 16'h0000;

    typedef struct packed {
        logic          en;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          iwe;
        logic          dwe;
        logic          idone;
        logic          ddone;
        logic          wdone;
        logic [2:0]    idx;
        logic [DW-1:0] data;
        logic          busy;
    } obs_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic obs_t snap();
        obs_t o;
        o.en    = bus.mem_en;
        o.wr    = bus.mem_wr;
        o.addr  = bus.mem_addr;
        o.wdata = bus.mem_wdata;
        o.iwe   = bus.i_fill_we;
        o.dwe   = bus.d_fill_we;
        o.idone = bus.i_fill_done;
        o.ddone = bus.d_fill_done;
        o.wdone = bus.d_wr_done;
        o.idx   = bus.fill_idx;
        o.data  = bus.fill_data;
        o.busy  = bus.busy;
        return o;
    endfunction

    // Expected outputs in cycle c of a fill whose miss was seen in cycle 0.
    function automatic obs_t exp_fill(input bit is_d, input logic [AW-1:0] base, input int c);
        obs_t o;
        o = '0;
        if (c >= 1 && c <= 8) begin
            o.en   = 1'b1;
            o.addr = base + 16'(2 * (c - 1));
        end
        if (c >= 5 && c <= 12) begin
            if (is_d) o.dwe = 1'b1;
            else      o.iwe = 1'b1;
            o.idx  = 3'(c - 5);
            o.data = (base + 16'(2 * (c - 5))) ^ 16'hA5A5;
        end
        if (c == 12) begin
            if (is_d) o.ddone = 1'b1;
            else      o.idone = 1'b1;
        end
        o.busy = (c >= 1 && c <= 12);
        return o;
    endfunction

    task automatic set_miss(input bit is_d, input logic v);
        if (is_d) bus.d_miss = v;
        else      bus.i_miss = v;
    endtask

    // Checks cycles 1..12 of a fill and the idle cycle after it; the miss
    // is dropped in cycle drop_c (if nonzero) and always with the done pulse.
    task automatic fill_seq(input bit is_d, input logic [AW-1:0] base, input int drop_c,
                            input string name);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d", name, c), snap(), exp_fill(is_d, base, c));
            if (c == drop_c || c == 12) set_miss(is_d, 1'b0);
        end
        @(negedge clk);
        chk($sformatf("%s idle", name), snap(), '0);
        $display("txn %s: %s fill base=%h", name, is_d ? "D" : "I", base);
    endtask

    obs_t wr_exp;

    initial begin
        bus.i_miss    = 1'b0;
        bus.i_addr    = '0;
        bus.d_miss    = 1'b0;
        bus.d_addr    = '0;
        bus.d_wr_req  = 1'b0;
        bus.d_wr_data = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset", snap(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", snap(), '0);
        $display("txn reset: outputs idle");

        // 1: single I fill.
        bus.i_addr = 16'h1236;
        bus.i_miss = 1'b1;
        #1 chk("t1 c0", snap(), '0);
        fill_seq(1'b0, 16'h1230, 0, "t1");

        // 2: simultaneous misses, D first, then I after one idle cycle.
        bus.i_addr = 16'h2000;
        bus.d_addr = 16'h3458;
        bus.i_miss = 1'b1;
        bus.d_miss = 1'b1;
        #1 chk("t2 c0", snap(), '0);
        fill_seq(1'b1, 16'h3450, 0, "t2d");
        fill_seq(1'b0, 16'h2000, 0, "t2i");

        // 3: write-through store.
        bus.d_addr    = 16'h0040;
        bus.d_wr_data = 16'hBEEF;
        bus.d_wr_req  = 1'b1;
        wr_exp        = '0;
        wr_exp.en     = 1'b1;
        wr_exp.wr     = 1'b1;
        wr_exp.addr   = 16'h0040;
        wr_exp.wdata  = 16'hBEEF;
        wr_exp.wdone  = 1'b1;
        wr_exp.busy   = 1'b1;
        @(negedge clk);
        chk("t3 write", snap(), wr_exp);
        bus.d_wr_req = 1'b0;
        @(negedge clk);
        chk("t3 idle", snap(), '0);
        $display("txn t3: store addr=0040 data=BEEF");

        // 3b: store beats a concurrent I miss; I fill follows.
        bus.d_addr    = 16'h0050;
        bus.d_wr_data = 16'h1234;
        bus.d_wr_req  = 1'b1;
        bus.i_addr    = 16'h0504;
        bus.i_miss    = 1'b1;
        wr_exp.addr   = 16'h0050;
        wr_exp.wdata  = 16'h1234;
        @(negedge clk);
        chk("t3b write", snap(), wr_exp);
        bus.d_wr_req = 1'b0;
        @(negedge clk);
        chk("t3b grant", snap(), '0);
        fill_seq(1'b0, 16'h0500, 0, "t3b");

        // 4: reset during cycle 6 of an I fill, then a clean D fill.
        bus.i_addr = 16'h0100;
        bus.i_miss = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("t4 pre c%0d", c), snap(), exp_fill(1'b0, 16'h0100, c));
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_miss = 1'b0;
        #1 chk("t4 in reset", snap(), '0);
        @(negedge clk);
        rst_n      = 1'b1;
        bus.d_addr = 16'h0A0C;
        bus.d_miss = 1'b1;
        #1 chk("t4 released", snap(), '0);
        fill_seq(1'b1, 16'h0A00, 0, "t4d");

        // 5: I miss dropped in cycle 3; fill still completes.
        bus.i_addr = 16'h7FF2;
        bus.i_miss = 1'b1;
        fill_seq(1'b0, 16'h7FF0, 3, "t5");

        // 6: spurious mem_rvalid in IDLE is ignored.
        spur = 1'b1;
        #1 chk("t6 spurious", snap(), '0);
        @(negedge clk);
        spur = 1'b0;
        #1 chk("t6 after", snap(), '0);
        $display("txn t6: spurious rvalid ignored");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
